// File: rtl/rider_sense_pkg.sv
// ---------------------------------------------------------------------------
// rider_sense_pkg
//   Shared widths, default weight thresholds, the settle-timer width and the
//   flag bundle used by rider_sense.
//   Optional feature macro: FAST_SIM_EN selects a short settle timer
//   (TMR_W=15, ~655 us at 50 MHz) instead of the real one (TMR_W=26, ~1.34 s).
// ---------------------------------------------------------------------------
package rider_sense_pkg;

  localparam int LD_W  = 12;  // load-cell reading width
  localparam int SUM_W = 13;  // left+right sum, never overflows

  localparam logic [LD_W-1:0] MIN_RIDER_WT_DEF  = 12'h200;
  localparam logic [LD_W-1:0] WT_HYSTERESIS_DEF = 12'h40;

`ifdef FAST_SIM_EN
  localparam int TMR_W = 15;
`else
  localparam int TMR_W = 26;
`endif

  typedef struct packed {
    logic sum_gt_min;
    logic sum_lt_min;
    logic diff_gt_eigth;
    logic diff_gt_15_16;
  } flags_t;

  // Power-up assumes nobody is standing on the platform.
  localparam flags_t FLAGS_RST = '{sum_gt_min: 1'b0, sum_lt_min: 1'b1,
                                   diff_gt_eigth: 1'b0, diff_gt_15_16: 1'b0};

  function automatic logic [LD_W-1:0] abs_diff(input logic [LD_W-1:0] a,
                                               input logic [LD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/rider_sense_if.sv
// ---------------------------------------------------------------------------
// rider_sense_if
//   Load-cell sample bus into rider_sense and the weight/balance flags out.
//   master : A2D side / consumer (drives samples, reads flags)
//   slave  : rider_sense
//   Signals: lft_ld, rght_ld, ld_vld (sample + strobe);
//            sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, flags_vld.
// ---------------------------------------------------------------------------
interface rider_sense_if;
  import rider_sense_pkg::*;

  logic [LD_W-1:0] lft_ld;
  logic [LD_W-1:0] rght_ld;
  logic            ld_vld;
  logic            sum_gt_min;
  logic            sum_lt_min;
  logic            diff_gt_eigth;
  logic            diff_gt_15_16;
  logic            flags_vld;

  modport master (
    output lft_ld, rght_ld, ld_vld,
    input  sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, flags_vld
  );

  modport slave (
    input  lft_ld, rght_ld, ld_vld,
    output sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, flags_vld
  );
endinterface

// File: rtl/rider_tmr.sv
// ---------------------------------------------------------------------------
// rider_tmr
//   Saturating rider-settle counter. Counts up from 0 and parks at all-ones;
//   clr_tmr reloads 0 and wins over both increment and saturation.
//   Ports: clk, rst_n (sync, active-low), clr_tmr, tmr_full.
//   Width comes from TMR_W (FAST_SIM_EN selects the short simulation value).
// ---------------------------------------------------------------------------
module rider_tmr
  import rider_sense_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_tmr,
  output logic tmr_full
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_tmr)     cnt_d = '0;
    else if (!(&cnt_q)) cnt_d = cnt_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tmr_full = &cnt_q;

endmodule

// File: rtl/rider_sense.sv
// ---------------------------------------------------------------------------
// rider_sense
//   Turns raw left/right load-cell readings into weight and balance flags for
//   the steering-enable state machine, and hosts the rider-settle timer.
//   Three-stage pipeline: capture -> sum/|diff| -> flags. Latency 2 edges,
//   full throughput, no backpressure. Flags hold between samples.
//   Ports:
//     clk, rst_n     : clock, synchronous active-low reset
//     ld_if (slave)  : lft_ld, rght_ld, ld_vld in; four flags + flags_vld out
//     clr_tmr        : clear settle timer
//     tmr_full       : settle timer expired (saturating)
//   Macro: FAST_SIM_EN shortens the settle timer for simulation.
// ---------------------------------------------------------------------------
module rider_sense
  import rider_sense_pkg::*;
#(
  parameter logic [LD_W-1:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
  parameter logic [LD_W-1:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  rider_sense_if.slave  ld_if,
  input  logic          clr_tmr,
  output logic          tmr_full
);

  // Thresholds in sum width; low threshold clamps at 0 so sum_lt_min can
  // never assert when the hysteresis exceeds the nominal weight.
  localparam logic [SUM_W-1:0] SUM_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
  localparam logic [SUM_W-1:0] SUM_LO = (MIN_RIDER_WT >= WT_HYSTERESIS) ?
                                        {1'b0, MIN_RIDER_WT - WT_HYSTERESIS} : '0;

  // Stage 0: captured sample
  logic [LD_W-1:0]  lft_q, rght_q;
  logic             v0_q;
  // Stage 1: sum and magnitude of difference
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [LD_W-1:0]  diff_q, diff_d;
  logic             v1_q;
  // Stage 2: flags
  flags_t           flags_q, flags_d;
  logic             flags_vld_q;

  always_comb begin
    sum_d  = {1'b0, lft_q} + {1'b0, rght_q};
    diff_d = abs_diff(lft_q, rght_q);
  end

  always_comb begin
    flags_d               = flags_q;
    flags_d.sum_gt_min    = sum_q > SUM_HI;
    flags_d.sum_lt_min    = sum_q < SUM_LO;
    flags_d.diff_gt_eigth = {1'b0, diff_q} > (sum_q >> 3);
    flags_d.diff_gt_15_16 = {1'b0, diff_q} > (sum_q - (sum_q >> 4));
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide
  // whether their contents are ever used.
  always_ff @(posedge clk) begin
    if (ld_if.ld_vld) begin
      lft_q  <= ld_if.lft_ld;
      rght_q <= ld_if.rght_ld;
    end
    sum_q  <= sum_d;
    diff_q <= diff_d;
  end

  // Control: valid bits and the flag outputs. Reset drops in-flight samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      flags_q     <= FLAGS_RST;
      flags_vld_q <= 1'b0;
    end else begin
      v0_q        <= ld_if.ld_vld;
      v1_q        <= v0_q;
      flags_vld_q <= v1_q;
      if (v1_q) flags_q <= flags_d;
    end
  end

  assign ld_if.sum_gt_min    = flags_q.sum_gt_min;
  assign ld_if.sum_lt_min    = flags_q.sum_lt_min;
  assign ld_if.diff_gt_eigth = flags_q.diff_gt_eigth;
  assign ld_if.diff_gt_15_16 = flags_q.diff_gt_15_16;
  assign ld_if.flags_vld     = flags_vld_q;

  rider_tmr #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_tmr  (clr_tmr),
    .tmr_full (tmr_full)
  );

endmodule

// File: doc/rider_sense.md
# rider_sense

Front end for the steering-enable state machine: it turns raw left/right load-cell readings into the weight and balance flags (`sum_gt_min`, `sum_lt_min`, `diff_gt_eigth`, `diff_gt_15_16`) that the state machine consumes. It also owns the 1.3 s rider-settle timer, which the state machine clears through `clr_tmr` and observes through `tmr_full`. It sits between the A2D load-cell interface and `steer_en_SM`.

## Interface
- `MIN_RIDER_WT`, default 12'h200: nominal minimum rider weight, in summed load-cell counts.
- `WT_HYSTERESIS`, default 12'h40: symmetric hysteresis applied around `MIN_RIDER_WT`.
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: reset. Synchronous, active-low.
- `lft_ld`  in  12: left load-cell reading, unsigned.
- `rght_ld`  in  12: right load-cell reading, unsigned.
- `ld_vld`  in  1: single-cycle strobe marking a new `lft_ld`/`rght_ld` pair.
- `clr_tmr`  in  1: synchronous clear of the settle timer, driven from the state machine.
- `sum_gt_min`  out  1: sum > `MIN_RIDER_WT` + `WT_HYSTERESIS`.
- `sum_lt_min`  out  1: sum < `MIN_RIDER_WT` − `WT_HYSTERESIS`.
- `diff_gt_eigth`  out  1: |diff| > sum/8.
- `diff_gt_15_16`  out  1: |diff| > sum·15/16.
- `flags_vld`  out  1: one-cycle pulse when the four flags update.
- `tmr_full`  out  1: settle timer has expired. Saturating.

## Operation
- **Pipeline stage 0:** on an edge with `ld_vld`=1, capture `lft_ld` and `rght_ld`; set `v0`.
- **Stage 1:** compute and register:
  - `sum` = lft + rght, 13 bits, zero-extended, no overflow.
  - `diff` = |lft − rght|, 12 bits.
  - Propagate valid as `v1`.
- **Stage 2:** compute and register the four flags from the stage-1 registers; set `flags_vld` = `v1`.
  - `diff_gt_eigth` = `diff` > (`sum` >> 3).
  - `diff_gt_15_16` = `diff` > (`sum` − (`sum` >> 4)).
  - Sum thresholds are computed 13 bits wide. If `MIN_RIDER_WT` < `WT_HYSTERESIS`, the low threshold clamps to 0, so `sum_lt_min` is never set.
- Flags hold their values between samples.
- Between the two thresholds (inclusive), `sum_gt_min` and `sum_lt_min` are both 0.
- Back-to-back `ld_vld` on every cycle is supported at full throughput; there is no stall and no backpressure.
- **Timer:** a `TMR_W`-bit up-counter.
  - `clr_tmr`=1 loads 0. `clr_tmr` takes priority over increment and over saturation.
  - Otherwise the counter increments while not all-ones.
  - `tmr_full` = &counter, combinational from the counter register. It holds until `clr_tmr`.

## Timing
- Reset values:
  - `sum_lt_min`=1 (no rider).
  - `sum_gt_min`=0, `diff_gt_eigth`=0, `diff_gt_15_16`=0, `flags_vld`=0.
  - Timer counter=0, so `tmr_full`=0.
  - Pipeline valid bits `v0`, `v1` = 0.
- Latency: `ld_vld` sampled at edge k → flags and `flags_vld` are visible after edge k+2.
- Reset mid-pipeline discards in-flight samples. No `flags_vld` pulse is produced for them.
- Timer: after `clr_tmr` is deasserted at edge c, `tmr_full` rises after edge c + 2^`TMR_W` − 1.
- `clr_tmr` asserted while `tmr_full`=1: `tmr_full` drops after the same edge.

## Configuration
- `FAST_SIM_EN` defined: `TMR_W`=15, so the settle time is about 655 µs at 50 MHz, for simulation.
- `FAST_SIM_EN` undefined: `TMR_W`=26, so the settle time is 2^26 cycles ≈ 1.34 s at 50 MHz.
- The rest of the logic is identical in both builds.

## Structure
- Package `rider_sense_pkg` holds:
  - `LD_W`=12 and `SUM_W`=13.
  - Default `MIN_RIDER_WT` and `WT_HYSTERESIS`.
  - The `TMR_W` selection for both `FAST_SIM_EN` settings.
- Sub-module `rider_tmr` contains the saturating settle counter. Ports: `clk`, `rst_n`, `clr_tmr`, `tmr_full`.
- The top level contains the three-stage comparator pipeline.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 edges → `sum_lt_min`=1, all other flags 0, `tmr_full`=0, `flags_vld`=0.
- **Balanced rider:** lft=rght=0x150 → `sum_gt_min`=1, `sum_lt_min`=0, both diff flags 0, `flags_vld` pulses exactly 2 edges after the `ld_vld` edge.
- **Leaning rider:** lft=0x180, rght=0x100 (sum 0x280, diff 0x80 > 0x50, 0x80 ≤ 0x258) → `diff_gt_eigth`=1, `diff_gt_15_16`=0.
- **Stepping off:** lft=0x300, rght=0x000 (diff 0x300 > 0x2D0) → `diff_gt_eigth`=1 and `diff_gt_15_16`=1.
- **Hysteresis band:** sum 0x200 → `sum_gt_min`=0 and `sum_lt_min`=0.
- **Back-to-back samples:** 3 consecutive `ld_vld` cycles → 3 consecutive `flags_vld` pulses with matching flags.
- **Timer (`FAST_SIM_EN`):**
  - `clr_tmr` low for 32766 cycles → `tmr_full` still 0.
  - 32767 cycles → `tmr_full`=1, and it stays 1.
  - One `clr_tmr` pulse → `tmr_full`=0 after the next edge.
